// File: rtl/mcp2515_pkg.sv
// Shared opcodes, register map, reset values and FSM states for the MCP2515 SPI responder.
package mcp2515_pkg;

  localparam logic [7:0] OP_RESET  = 8'hC0;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_BITMOD = 8'h05;

  localparam logic [7:0] ADDR_CANSTAT  = 8'h0E;
  localparam logic [7:0] ADDR_CANCTRL  = 8'h0F;
  localparam logic [7:0] ADDR_CANINTE  = 8'h2B;
  localparam logic [7:0] ADDR_CANINTF  = 8'h2C;
  localparam logic [7:0] ADDR_TXB0CTRL = 8'h30;

  localparam logic [7:0] CANSTAT_RST = 8'h80;
  localparam logic [7:0] CANCTRL_RST = 8'h87;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_RST_WAIT,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_IGNORE,
    ST_BM_ADDR,
    ST_BM_MASK,
    ST_BM_DATA
  } state_e;

  function automatic logic [7:0] reg_reset_val(input logic [7:0] addr);
    case (addr)
      ADDR_CANSTAT: return CANSTAT_RST;
      ADDR_CANCTRL: return CANCTRL_RST;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mcp_spi_byte_if.sv
// SPI mode-0 byte interface: synchronizes cs/sck/si, assembles rx bytes on sck rise and
// shifts tx bytes out on sck fall, loading a new tx byte at each byte boundary.
module mcp_spi_byte_if #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       sck,
  input  logic       si,
  input  logic [7:0] tx_byte,
  output logic       cs_fall_c,
  output logic       cs_rise_c,
  output logic       byte_valid_c,
  output logic [7:0] rx_byte_c,
  output logic       load_req_c,
  output logic       so
);

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, si_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic [2:0]             cnt_q, cnt_d;
  logic [6:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic                   so_q, so_d;
  logic                   boundary_q, boundary_d;
  logic                   cs_s, sck_s, si_s;
  logic                   sck_rise_c, sck_fall_c;

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign si_s  = si_sync_q[SYNC_STAGES-1];
  assign so    = so_q;

  // Bit/byte sequencing; boundary_q marks that the next sck fall starts a new tx byte.
  always_comb begin
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    so_d         = so_q;
    boundary_d   = boundary_q;
    sck_rise_c   = sck_s & ~sck_prev_q;
    sck_fall_c   = ~sck_s & sck_prev_q;
    cs_fall_c    = cs_prev_q & ~cs_s;
    cs_rise_c    = ~cs_prev_q & cs_s;
    rx_byte_c    = {rx_q, si_s};
    byte_valid_c = 1'b0;
    load_req_c   = 1'b0;
    if (cs_s) begin
      cnt_d      = 3'd0;
      tx_d       = 8'h00;
      so_d       = 1'b0;
      boundary_d = 1'b0;
    end else if (cs_fall_c) begin
      cnt_d      = 3'd0;
      boundary_d = 1'b0;
    end else if (sck_rise_c) begin
      rx_d  = rx_byte_c[6:0];
      cnt_d = 3'(cnt_q + 3'd1);
      if (cnt_q == 3'd7) begin
        byte_valid_c = 1'b1;
        boundary_d   = 1'b1;
      end
    end else if (sck_fall_c) begin
      if (boundary_q) begin
        so_d       = tx_byte[7];
        tx_d       = {tx_byte[6:0], 1'b0};
        load_req_c = 1'b1;
        boundary_d = 1'b0;
      end else begin
        so_d = tx_q[7];
        tx_d = {tx_q[6:0], 1'b0};
      end
    end
  end

  // cs chain resets low so a frame already in progress at reset release is not seen as a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '0;
      sck_sync_q <= '0;
      si_sync_q  <= '0;
      cs_prev_q  <= 1'b0;
      sck_prev_q <= 1'b0;
      cnt_q      <= 3'd0;
      rx_q       <= 7'd0;
      tx_q       <= 8'h00;
      so_q       <= 1'b0;
      boundary_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], si};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      so_q       <= so_d;
      boundary_q <= boundary_d;
    end
  end

endmodule

// File: rtl/mcp2515_spi_responder.sv
// MCP2515 register-interface SPI responder: command FSM, register file, TXREQ/CANINTF/INT emulation.
// Define MCP2515_BITMOD_EN to enable the BIT MODIFY (0x05) command.
module mcp2515_spi_responder
  import mcp2515_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic cs,
  input  logic sck,
  input  logic si,
  output logic so,
  input  logic tx_done,
  output logic tx_req,
  output logic int_n
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] A_CANSTAT  = ADDR_W'(ADDR_CANSTAT);
  localparam logic [ADDR_W-1:0] A_CANCTRL  = ADDR_W'(ADDR_CANCTRL);
  localparam logic [ADDR_W-1:0] A_CANINTE  = ADDR_W'(ADDR_CANINTE);
  localparam logic [ADDR_W-1:0] A_CANINTF  = ADDR_W'(ADDR_CANINTF);
  localparam logic [ADDR_W-1:0] A_TXB0CTRL = ADDR_W'(ADDR_TXB0CTRL);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          regs_q [NREGS];
  logic [7:0]          regs_d [NREGS];
  logic                int_n_q, int_n_d;
`ifdef MCP2515_BITMOD_EN
  logic [7:0]          mask_q, mask_d;
`endif

  logic                cs_fall_c, cs_rise_c, byte_valid_c, load_req_c;
  logic [7:0]          rx_byte_c, tx_byte_c;
  logic                wr_en_c, rst_regs_c;
  logic [7:0]          wr_data_c;

  mcp_spi_byte_if #(.SYNC_STAGES(SYNC_STAGES)) u_byte_if (
    .clk          (clk50),
    .rst_n        (rst_n),
    .cs           (cs),
    .sck          (sck),
    .si           (si),
    .tx_byte      (tx_byte_c),
    .cs_fall_c    (cs_fall_c),
    .cs_rise_c    (cs_rise_c),
    .byte_valid_c (byte_valid_c),
    .rx_byte_c    (rx_byte_c),
    .load_req_c   (load_req_c),
    .so           (so)
  );

  assign tx_byte_c = (state_q == ST_RD_DATA) ? regs_q[addr_q] : 8'h00;
  assign tx_req    = regs_q[A_TXB0CTRL][3];
  assign int_n     = int_n_q;

  // Command decode and address sequencing.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_en_c    = 1'b0;
    wr_data_c  = rx_byte_c;
    rst_regs_c = 1'b0;
`ifdef MCP2515_BITMOD_EN
    mask_d     = mask_q;
`endif
    if (cs_rise_c) begin
      state_d    = ST_IDLE;
      rst_regs_c = (state_q == ST_RST_WAIT);
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall_c) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_valid_c) begin
            case (rx_byte_c)
              OP_RESET:  state_d = ST_RST_WAIT;
              OP_WRITE:  state_d = ST_WR_ADDR;
              OP_READ:   state_d = ST_RD_ADDR;
`ifdef MCP2515_BITMOD_EN
              OP_BITMOD: state_d = ST_BM_ADDR;
`endif
              default:   state_d = ST_IGNORE;
            endcase
          end
        end
        ST_WR_ADDR: begin
          if (byte_valid_c) begin
            addr_d  = rx_byte_c[ADDR_W-1:0];
            state_d = ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (byte_valid_c) begin
            wr_en_c = 1'b1;
            addr_d  = ADDR_W'(addr_q + 1'b1);
          end
        end
        ST_RD_ADDR: begin
          if (byte_valid_c) begin
            addr_d  = rx_byte_c[ADDR_W-1:0];
            state_d = ST_RD_DATA;
          end
        end
        ST_RD_DATA: if (load_req_c) addr_d = ADDR_W'(addr_q + 1'b1);
`ifdef MCP2515_BITMOD_EN
        ST_BM_ADDR: begin
          if (byte_valid_c) begin
            addr_d  = rx_byte_c[ADDR_W-1:0];
            state_d = ST_BM_MASK;
          end
        end
        ST_BM_MASK: begin
          if (byte_valid_c) begin
            mask_d  = rx_byte_c;
            state_d = ST_BM_DATA;
          end
        end
        ST_BM_DATA: begin
          if (byte_valid_c) begin
            wr_en_c   = 1'b1;
            wr_data_c = (regs_q[addr_q] & ~mask_q) | (rx_byte_c & mask_q);
            state_d   = ST_IGNORE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Register file update: SPI write, CANSTAT mode tracking, tx_done override, RESET reload.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_c && (addr_q != A_CANSTAT)) regs_d[addr_q] = wr_data_c;
    regs_d[A_CANSTAT][7:5] = regs_q[A_CANCTRL][7:5];
    if (tx_done) begin
      regs_d[A_TXB0CTRL][3] = 1'b0;
      regs_d[A_CANINTF][2]  = 1'b1;
    end
    if (rst_regs_c) begin
      for (int i = 0; i < NREGS; i++) regs_d[i] = reg_reset_val(8'(i));
    end
    int_n_d = ~|(regs_q[A_CANINTE] & regs_q[A_CANINTF]);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      int_n_q <= 1'b1;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= reg_reset_val(8'(i));
`ifdef MCP2515_BITMOD_EN
      mask_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      int_n_q <= int_n_d;
      regs_q  <= regs_d;
`ifdef MCP2515_BITMOD_EN
      mask_q  <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_mcp2515_spi_responder.sv
// Scoreboard bench for mcp2515_spi_responder: expected so bytes and status levels are queued by
// the stimulus thread and checked by independent monitors. Honours MCP2515_BITMOD_EN.
module tb_mcp2515_spi_responder;

  localparam int HALF = 8;

  logic clk50 = 1'b0;
  logic rst_n, cs, sck, si, tx_done;
  logic so, tx_req, int_n;

  int checks   = 0;
  int failures = 0;

  typedef struct { string tag; logic [7:0] val; } so_exp_t;
  typedef struct { string tag; logic tx_req; logic int_n; } st_exp_t;
  so_exp_t so_q[$];
  st_exp_t st_q[$];

  always #10 clk50 = ~clk50;

  mcp2515_spi_responder dut (
    .clk50   (clk50),
    .rst_n   (rst_n),
    .cs      (cs),
    .sck     (sck),
    .si      (si),
    .so      (so),
    .tx_done (tx_done),
    .tx_req  (tx_req),
    .int_n   (int_n)
  );

  // so monitor: master-side capture on sck rise, one comparison per completed byte.
  logic [7:0] mon_sh = 8'h00;
  int         mon_nb = 0;
  always @(posedge sck or posedge cs or negedge rst_n) begin
    if (!rst_n || cs) begin
      mon_nb = 0;
    end else begin
      mon_sh = {mon_sh[6:0], so};
      mon_nb++;
      if (mon_nb == 8) begin
        so_exp_t e;
        mon_nb = 0;
        checks++;
        if (so_q.size() == 0) begin
          failures++;
          $display("FAIL so_unexpected got=%02h", mon_sh);
        end else begin
          e = so_q.pop_front();
          if (mon_sh !== e.val) begin
            failures++;
            $display("FAIL %s so_byte got=%02h exp=%02h", e.tag, mon_sh, e.val);
          end
        end
      end
    end
  end

  // Status monitor: compares tx_req/int_n whenever an expectation is pending.
  always @(negedge clk50) begin
    if (st_q.size() > 0) begin
      st_exp_t e;
      e = st_q.pop_front();
      checks++;
      if (tx_req !== e.tx_req || int_n !== e.int_n) begin
        failures++;
        $display("FAIL %s status got tx_req=%b int_n=%b exp tx_req=%b int_n=%b",
                 e.tag, tx_req, int_n, e.tx_req, e.int_n);
      end
    end
  end

  initial begin
    #1200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      si = b[7-i];
      wait_clks(HALF);
      sck = 1'b1;
      wait_clks(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    cs = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic frame_end();
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic exp_so(input string tag, input logic [7:0] v);
    so_exp_t e;
    e.tag = tag;
    e.val = v;
    so_q.push_back(e);
  endtask

  task automatic exp_status(input string tag, input logic t, input logic i);
    st_exp_t e;
    wait_clks(8);
    e.tag    = tag;
    e.tx_req = t;
    e.int_n  = i;
    st_q.push_back(e);
    wait_clks(2);
  endtask

  task automatic spi_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    frame_begin();
    exp_so({tag, "_cmd"}, 8'h00);
    exp_so({tag, "_adr"}, 8'h00);
    exp_so({tag, "_dat"}, 8'h00);
    spi_bits(8'h02, 8);
    spi_bits(a, 8);
    spi_bits(d, 8);
    frame_end();
  endtask

  task automatic spi_read(input string tag, input logic [7:0] a, input logic [7:0] v);
    frame_begin();
    exp_so({tag, "_cmd"}, 8'h00);
    exp_so({tag, "_adr"}, 8'h00);
    exp_so(tag, v);
    spi_bits(8'h03, 8);
    spi_bits(a, 8);
    spi_bits(8'h00, 8);
    frame_end();
  endtask

  initial begin
    logic [7:0] bm_exp;
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; si = 1'b0; tx_done = 1'b0;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(10);

    exp_status("reset", 1'b0, 1'b1);
    spi_read("rd_canstat_rst", 8'h0E, 8'h80);
    spi_read("rd_canctrl_rst", 8'h0F, 8'h87);

    spi_write("wr_2a", 8'h2A, 8'h03);
    spi_read("rd_2a", 8'h2A, 8'h03);
    spi_write("wr_canctrl", 8'h0F, 8'h00);
    spi_read("rd_canstat_track", 8'h0E, 8'h00);

    // Sequential write and read across the 0x7F -> 0x00 wrap.
    frame_begin();
    for (int k = 0; k < 4; k++) exp_so("wr_wrap", 8'h00);
    spi_bits(8'h02, 8); spi_bits(8'h7F, 8); spi_bits(8'hAA, 8); spi_bits(8'h55, 8);
    frame_end();
    frame_begin();
    exp_so("rd_wrap_cmd", 8'h00); exp_so("rd_wrap_adr", 8'h00);
    exp_so("rd_wrap_7f", 8'hAA);  exp_so("rd_wrap_00", 8'h55);
    spi_bits(8'h03, 8); spi_bits(8'h7F, 8); spi_bits(8'h00, 8); spi_bits(8'h00, 8);
    frame_end();

    spi_write("wr_inte", 8'h2B, 8'h04);
    spi_write("wr_txreq", 8'h30, 8'h08);
    exp_status("txreq_set", 1'b1, 1'b1);
    tx_done = 1'b1;
    wait_clks(1);
    tx_done = 1'b0;
    exp_status("tx_done", 1'b0, 1'b0);
    spi_read("rd_canintf", 8'h2C, 8'h04);
    spi_read("rd_txb0ctrl", 8'h30, 8'h00);
    spi_write("wr_intf_clr", 8'h2C, 8'h00);
    exp_status("intf_clr", 1'b0, 1'b1);

    // Partial data byte is discarded.
    frame_begin();
    exp_so("partial_cmd", 8'h00); exp_so("partial_adr", 8'h00);
    spi_bits(8'h02, 8); spi_bits(8'h2A, 8); spi_bits(8'hFF, 4);
    frame_end();
    spi_read("rd_partial", 8'h2A, 8'h03);

    spi_write("wr_bm_base", 8'h2A, 8'hF0);
    frame_begin();
    for (int k = 0; k < 4; k++) exp_so("bitmod_so", 8'h00);
    spi_bits(8'h05, 8); spi_bits(8'h2A, 8); spi_bits(8'h0F, 8); spi_bits(8'h05, 8);
    frame_end();
`ifdef MCP2515_BITMOD_EN
    bm_exp = 8'hF5;
`else
    bm_exp = 8'hF0;
`endif
    spi_read("rd_bitmod", 8'h2A, bm_exp);

    // Hardware reset in the middle of a write frame.
    spi_write("wr_tx_pre_rst", 8'h30, 8'h08);
    exp_status("txreq_pre_rst", 1'b1, 1'b1);
    frame_begin();
    exp_so("rstn_cmd", 8'h00); exp_so("rstn_adr", 8'h00); exp_so("rstn_tail", 8'h00);
    spi_bits(8'h02, 8); spi_bits(8'h2A, 8);
    rst_n = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    spi_bits(8'h55, 8);
    frame_end();
    exp_status("rstn_status", 1'b0, 1'b1);
    spi_read("rd_rstn_2a", 8'h2A, 8'h00);
    spi_read("rd_rstn_canctrl", 8'h0F, 8'h87);

    // RESET command restores everything on cs rise.
    spi_write("wr_pre_c0_2a", 8'h2A, 8'h33);
    spi_write("wr_pre_c0_ctrl", 8'h0F, 8'h40);
    spi_read("rd_canstat_40", 8'h0E, 8'h40);
    spi_write("wr_pre_c0_tx", 8'h30, 8'h08);
    spi_write("wr_pre_c0_inte", 8'h2B, 8'hFF);
    spi_write("wr_pre_c0_intf", 8'h2C, 8'h01);
    exp_status("pre_c0", 1'b1, 1'b0);
    frame_begin();
    exp_so("c0_cmd", 8'h00);
    spi_bits(8'hC0, 8);
    frame_end();
    exp_status("post_c0", 1'b0, 1'b1);
    spi_read("rd_c0_2a", 8'h2A, 8'h00);
    spi_read("rd_c0_canctrl", 8'h0F, 8'h87);
    spi_read("rd_c0_canstat", 8'h0E, 8'h80);
    spi_read("rd_c0_canintf", 8'h2C, 8'h00);
    spi_read("rd_c0_7f", 8'h7F, 8'h00);

    wait_clks(20);
    checks++;
    if (so_q.size() != 0 || st_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations so=%0d status=%0d exp=0", so_q.size(), st_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
